lock_supervisor: RTL and testbench

//  Supervisory controller for the 4-key sequential lock core (code A,B,C,D).
//  - Edge-detects raw key levels and forwards single-cycle one-hot strobes to the core.
//  - Judges each 4-press attempt, counts failures and enforces a lockout period.
//  - Holds the door open for a fixed time, then re-arms the core through its clear input.

---
 rtl/lock_supervisor.sv | 145 ++++++++++++++
 tb/tb_lock_supervisor.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lock_supervisor.sv
// Supervisory controller for a 4-key sequential lock core: edge-detects keys,
// forwards one-hot strobes, judges attempts, and runs the open/lockout timers.
module lock_supervisor #(
    parameter int MAX_FAILS      = 3,
    parameter int ENTRY_TIMEOUT  = 2000,
    parameter int OPEN_CYCLES    = 500,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_in,
    input  logic       core_unlocked,
    output logic [3:0] core_key,
    output logic       core_clr,
    output logic       door_open,
    output logic       lockout,
    output logic [1:0] fail_cnt,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, ENTRY = 2'd1, OPEN = 2'd2, LOCKOUT = 2'd3} state_t;

    // Timers are loaded with N-1 and act at zero, giving a dwell of exactly N cycles.
    localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] OPEN_LOAD  = CNT_W'(OPEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LOAD  = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [1:0]       MAX_F      = 2'(MAX_FAILS);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [2:0]       press_cnt_q, press_cnt_d;
    logic [1:0]       fail_q, fail_d, fail_next;
    logic [3:0]       key_prev_q;
    logic [3:0]       key_q, key_d;
    logic             clr_q, clr_d;
    logic [3:0]       press;
    logic             valid_press, invalid_press, waiting, fail_evt;

    // core_key has no ready: each strobe is a single-cycle one-hot pulse the core must take.
    assign press         = key_in & ~key_prev_q;
    assign valid_press   = (press != 4'd0) && ((press & (press - 4'd1)) == 4'd0);
    assign invalid_press = (press != 4'd0) && !valid_press;
    assign waiting       = (press_cnt_q == 3'd4);
    assign fail_next     = (fail_q == MAX_F) ? fail_q : fail_q + 2'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            press_cnt_q <= '0;
            fail_q      <= '0;
            key_prev_q  <= 4'b1111;
            key_q       <= '0;
            clr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            press_cnt_q <= press_cnt_d;
            fail_q      <= fail_d;
            key_prev_q  <= key_in;
            key_q       <= key_d;
            clr_q       <= clr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        press_cnt_d = press_cnt_q;
        fail_d      = fail_q;
        key_d       = 4'd0;
        clr_d       = 1'b0;
        fail_evt    = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_press) begin
                    key_d       = press;
                    press_cnt_d = 3'd1;
                    timer_d     = ENTRY_LOAD;
                    state_d     = ENTRY;
                end else if (invalid_press) begin
                    fail_evt = 1'b1;
                end
            end
            ENTRY: begin
                if (core_unlocked) begin
                    state_d     = OPEN;
                    timer_d     = OPEN_LOAD;
                    fail_d      = 2'd0;
                    press_cnt_d = 3'd0;
                end else if (waiting) begin
                    // Timer of 1 spans the core's two-cycle path to its unlocked flag.
                    if (timer_q == '0) fail_evt = 1'b1;
                    else               timer_d  = timer_q - 1'b1;
                end else if (valid_press) begin
                    key_d       = press;
                    press_cnt_d = press_cnt_q + 3'd1;
                    timer_d     = (press_cnt_q == 3'd3) ? CNT_W'(1) : ENTRY_LOAD;
                end else if (invalid_press || timer_q == '0) begin
                    fail_evt = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            OPEN: begin
                if (timer_q == '0) begin
                    clr_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            LOCKOUT: begin
                if (timer_q == '0) begin
                    fail_d  = 2'd0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (fail_evt) begin
            clr_d       = 1'b1;
            press_cnt_d = 3'd0;
            fail_d      = fail_next;
            if (fail_next == MAX_F) begin
                state_d = LOCKOUT;
                timer_d = LOCK_LOAD;
            end else begin
                state_d = IDLE;
            end
        end
    end

    assign core_key  = key_q;
    assign core_clr  = clr_q | ~rst;
    assign door_open = (state_q == OPEN);
    assign lockout   = (state_q == LOCKOUT);
    assign fail_cnt  = fail_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_lock_supervisor.sv
// Bench for lock_supervisor: behavioural lock core, strobe scoreboard and
// directed scenarios covering unlock, failures, lockout, timeout and reset.
module tb_lock_supervisor;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_in;
    logic       core_unlocked;
    logic [3:0] core_key;
    logic       core_clr;
    logic       door_open;
    logic       lockout;
    logic [1:0] fail_cnt;
    logic [1:0] dbg_state;

    logic [3:0] exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    localparam logic [3:0] KA = 4'b0001, KB = 4'b0010, KC = 4'b0100, KD = 4'b1000;
    localparam logic [31:0] S_IDLE = 32'd0, S_ENTRY = 32'd1, S_OPEN = 32'd2, S_LOCK = 32'd3;

    lock_supervisor dut (
        .clk           (clk),
        .rst           (rst),
        .key_in        (key_in),
        .core_unlocked (core_unlocked),
        .core_key      (core_key),
        .core_clr      (core_clr),
        .door_open     (door_open),
        .lockout       (lockout),
        .fail_cnt      (fail_cnt),
        .dbg_state     (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // lock core model: code A,B,C,D, registered unlocked flag, clear wins
    logic [2:0] core_pos;
    logic       core_ok;
    always @(posedge clk) begin
        if (!rst || core_clr) begin
            core_pos      <= 3'd0;
            core_ok       <= 1'b1;
            core_unlocked <= 1'b0;
        end else if (core_key != 4'd0 && core_pos < 3'd4) begin
            core_pos <= core_pos + 3'd1;
            core_ok  <= core_ok && (core_key == (4'b0001 << core_pos));
            if (core_pos == 3'd3 && core_ok && core_key == 4'b1000)
                core_unlocked <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // scoreboard: every nonzero strobe must match the oldest expected press
    always @(negedge clk) begin
        if (core_key != 4'd0) begin
            if (exp_q.size() == 0) check("strobe_unexpected", 32'(core_key), 32'd0);
            else                   check("strobe", 32'(core_key), 32'(exp_q.pop_front()));
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k, input bit fwd, input int gap);
        key_in = k;
        if (fwd) exp_q.push_back(k);
        tick(1);
        key_in = 4'd0;
        if (gap > 0) tick(gap);
    endtask

    // four presses; returns in the strobe cycle of the last one
    task automatic attempt(input logic [15:0] seq, input int gap);
        for (int i = 0; i < 4; i++) press(seq[4*i +: 4], 1'b1, (i == 3) ? 0 : gap);
    endtask

    task automatic wait_low_open(input int limit, output int cnt);
        cnt = 0;
        while (door_open && cnt < limit) begin
            cnt++;
            tick(1);
        end
    endtask

    localparam logic [15:0] CODE_OK  = {KD, KC, KB, KA};
    localparam logic [15:0] CODE_ACB = {KD, KB, KC, KA};
    localparam logic [15:0] CODE_REV = {KA, KB, KC, KD};
    localparam logic [15:0] CODE_BAC = {KD, KC, KA, KB};

    initial begin
        int cnt;
        rst    = 1'b0;
        key_in = 4'd0;
        tick(3);
        check("rst_clr", 32'(core_clr), 32'd1);
        check("rst_state", 32'(dbg_state), S_IDLE);
        check("rst_outputs", {26'd0, core_key, door_open, lockout}, 32'd0);
        check("rst_fail", 32'(fail_cnt), 32'd0);
        rst = 1'b1;
        tick(1);
        check("clr_after_rst", 32'(core_clr), 32'd0);

        // correct code, 3 cycles apart
        attempt(CODE_OK, 2);
        tick(2);
        check("open_latency", 32'(door_open), 32'd1);
        wait_low_open(600, cnt);
        check("open_len", 32'(cnt), 32'd500);
        check("open_exit_clr", 32'(core_clr), 32'd1);
        check("open_exit_state", 32'(dbg_state), S_IDLE);
        tick(1);
        check("open_clr_pulse", 32'(core_clr), 32'd0);

        // wrong order
        attempt(CODE_ACB, 2);
        tick(1);
        check("wrong_fail_early", 32'(fail_cnt), 32'd0);
        tick(1);
        check("wrong_fail", 32'(fail_cnt), 32'd1);
        check("wrong_clr", 32'(core_clr), 32'd1);
        check("wrong_door", 32'(door_open), 32'd0);
        tick(1);
        check("wrong_clr_pulse", 32'(core_clr), 32'd0);

        // two more wrong attempts reach lockout; presses inside are dropped
        attempt(CODE_REV, 1);
        tick(2);
        check("fail2", 32'(fail_cnt), 32'd2);
        tick(1);
        attempt(CODE_BAC, 3);
        tick(2);
        check("lockout_on", 32'(lockout), 32'd1);
        check("lockout_fail", 32'(fail_cnt), 32'd3);
        cnt = 0;
        while (lockout && cnt < 1100) begin
            cnt++;
            key_in = (cnt % 97 == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            tick(1);
        end
        key_in = 4'd0;
        check("lockout_len", 32'(cnt), 32'd1000);
        check("lockout_exit_fail", 32'(fail_cnt), 32'd0);
        check("lockout_exit_state", 32'(dbg_state), S_IDLE);
        tick(2);

        // entry timeout
        press(KA, 1'b1, 0);
        cnt = 0;
        while (fail_cnt == 2'd0 && cnt < 2100) begin
            cnt++;
            tick(1);
        end
        check("timeout_len", 32'(cnt), 32'd2000);
        check("timeout_fail", 32'(fail_cnt), 32'd1);
        check("timeout_clr", 32'(core_clr), 32'd1);
        tick(2);

        // press on the last timer cycle reloads, then finish the code
        press(KA, 1'b1, 0);
        tick(1999);
        check("reload_pre", 32'(fail_cnt), 32'd1);
        press(KB, 1'b1, 0);
        check("reload_fail", 32'(fail_cnt), 32'd1);
        check("reload_state", 32'(dbg_state), S_ENTRY);
        press(KC, 1'b1, 1);
        press(KD, 1'b1, 0);
        tick(2);
        check("reload_open", 32'(door_open), 32'd1);
        check("reload_fail_clear", 32'(fail_cnt), 32'd0);
        press(KB, 1'b0, 3);
        wait_low_open(600, cnt);
        tick(2);

        // simultaneous keys, then a long hold
        press(KA | KC, 1'b0, 0);
        check("multi_fail", 32'(fail_cnt), 32'd1);
        check("multi_clr", 32'(core_clr), 32'd1);
        check("multi_state", 32'(dbg_state), S_IDLE);
        tick(1);
        key_in = KB;
        exp_q.push_back(KB);
        tick(50);
        key_in = 4'd0;
        tick(2);
        check("hold_state", 32'(dbg_state), S_ENTRY);

        // reset mid-entry with a key held through it
        rst    = 1'b0;
        key_in = KC;
        tick(1);
        check("rst_entry_state", 32'(dbg_state), S_IDLE);
        check("rst_entry_out", {26'd0, core_key, door_open, lockout}, 32'd0);
        check("rst_entry_fail", 32'(fail_cnt), 32'd0);
        check("rst_entry_clr", 32'(core_clr), 32'd1);
        tick(1);
        rst = 1'b1;
        tick(3);
        key_in = 4'd0;
        tick(2);

        // reset mid-open
        attempt(CODE_OK, 0);
        tick(2);
        check("open2", 32'(door_open), 32'd1);
        tick(10);
        rst = 1'b0;
        tick(1);
        check("rst_open_state", 32'(dbg_state), S_IDLE);
        check("rst_open_door", 32'(door_open), 32'd0);
        check("rst_open_clr", 32'(core_clr), 32'd1);
        rst = 1'b1;
        tick(3);
        check("rst_open_idle", 32'(dbg_state), S_IDLE);

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
